// File: rtl/logic_reduce_pipe_if.sv
// logic_reduce_pipe_if: sample, result and statistics bundle of logic_reduce_pipe
interface logic_reduce_pipe_if #(parameter int WIDTH = 5);
    logic             EN;
    logic             VALID_I;
    logic [WIDTH-1:0] I;
    logic             STICKY_CLR;
    logic             O;
    logic             VALID_O;
    logic             STICKY_O;
    logic [15:0]      CNT_O;
    modport master (output EN, VALID_I, I, STICKY_CLR, input O, VALID_O, STICKY_O, CNT_O);
    modport slave (input EN, VALID_I, I, STICKY_CLR, output O, VALID_O, STICKY_O, CNT_O);
endinterface

// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe: pipelined fan-in-4 OR/AND/XOR reduction; LOGIC_REDUCE_CNT_EN adds the hit counter
module logic_reduce_pipe #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(5'b00111),
    parameter int               MODE     = 0
) (
    input logic C,
    input logic CLR_N,
    logic_reduce_pipe_if.slave bus
);
    function automatic int nodes(int s);
        int n = WIDTH;
        for (int k = 0; k < s; k++) n = (n + 3) / 4;
        return n;
    endfunction
    function automatic int levels();
        int l = 0;
        for (int k = 1; k < 8; k++) if (nodes(k - 1) > 1) l = k;
        return l;
    endfunction
    function automatic int base(int s);
        int b = 0;
        for (int k = 1; k < s; k++) b += nodes(k);
        return b;
    endfunction
    function automatic logic op(logic a, logic b);
        return MODE == 1 ? a & b : MODE == 2 ? a ^ b : a | b;
    endfunction
    localparam int L = levels();
    localparam int T = base(L + 1);
    logic [WIDTH-1:0] x;
    logic [T-1:0]     tree, tree_nxt;
    logic [L-1:0]     vld, vld_nxt;
    logic             acc, hit, sticky;
    assign x = bus.I ^ INV_MASK;
    // next value of every tree node (stages packed back to back) and of the valid shift register
    always_comb begin
        tree_nxt = '0;
        acc = 1'b0;
        for (int s = 1; s <= L; s++)
            for (int j = 0; j < WIDTH; j++) begin
                acc = MODE == 1;
                for (int b = 0; b < 4; b++)
                    if (4 * j + b < nodes(s - 1))
                        acc = op(acc, s == 1 ? x[4 * j + b] : tree[base(s - 1) + 4 * j + b]);
                if (j < nodes(s)) tree_nxt[base(s) + j] = acc;
            end
        vld_nxt[0] = bus.VALID_I;
        for (int k = 1; k < L; k++) vld_nxt[k] = vld[k - 1];
    end
    assign hit = bus.EN & vld_nxt[L-1] & tree_nxt[T-1];
    // tree and valid registers advance together and freeze together
    always_ff @(posedge C or negedge CLR_N)
        if (!CLR_N) begin
            tree <= '0;
            vld  <= '0;
        end else if (bus.EN) begin
            tree <= tree_nxt;
            vld  <= vld_nxt;
        end
    // sticky flag: a hit in the same edge as a clear still leaves it set
    always_ff @(posedge C or negedge CLR_N)
        if (!CLR_N) sticky <= 1'b0;
        else sticky <= hit | (sticky & ~bus.STICKY_CLR);
`ifdef LOGIC_REDUCE_CNT_EN
    logic [15:0] cnt;
    // saturating hit counter; a clear coinciding with a hit restarts at one
    always_ff @(posedge C or negedge CLR_N)
        if (!CLR_N) cnt <= '0;
        else if (bus.STICKY_CLR) cnt <= {15'd0, hit};
        else if (hit && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    assign bus.CNT_O = cnt;
`else
    assign bus.CNT_O = 16'h0000;
`endif
    assign bus.O        = tree[T-1];
    assign bus.VALID_O  = vld[L-1];
    assign bus.STICKY_O = sticky;
endmodule

// File: tb/tb_logic_reduce_pipe.sv
// tb_logic_reduce_pipe: scoreboard bench for three logic_reduce_pipe configurations
`timescale 1ns/1ps
module tb_logic_reduce_pipe;
`ifdef LOGIC_REDUCE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int LAT [3] = '{2, 3, 1};
    logic clk = 1'b0, CLR_N = 1'b1;
    logic en = 1'b0, vi = 1'b0, sclr = 1'b0;
    logic [63:0] r0 = '0, r1 = '0, r2 = '0;
    int checks = 0, failures = 0, acc_cnt = 0, mon_cnt = 0;
    int q_due [3][$];
    bit q_exp [3][$];
    bit m_sticky [3];
    int m_cnt [3];
    logic prev_o [3], prev_v [3];
    logic o_a [3], v_a [3], s_a [3];
    logic [15:0] c_a [3];
    always #5 clk = ~clk;
    logic_reduce_pipe_if #(.WIDTH(5))  b0 ();
    logic_reduce_pipe_if #(.WIDTH(17)) b1 ();
    logic_reduce_pipe_if #(.WIDTH(3))  b2 ();
    logic_reduce_pipe u0 (.C(clk), .CLR_N(CLR_N), .bus(b0));
    logic_reduce_pipe #(.WIDTH(17), .INV_MASK(17'h0), .MODE(1)) u1 (.C(clk), .CLR_N(CLR_N), .bus(b1));
    logic_reduce_pipe #(.WIDTH(3), .INV_MASK(3'b101), .MODE(2)) u2 (.C(clk), .CLR_N(CLR_N), .bus(b2));
    assign b0.EN = en; assign b0.VALID_I = vi; assign b0.STICKY_CLR = sclr; assign b0.I = r0[4:0];
    assign b1.EN = en; assign b1.VALID_I = vi; assign b1.STICKY_CLR = sclr; assign b1.I = r1[16:0];
    assign b2.EN = en; assign b2.VALID_I = vi; assign b2.STICKY_CLR = sclr; assign b2.I = r2[2:0];
    assign o_a[0] = b0.O; assign v_a[0] = b0.VALID_O; assign s_a[0] = b0.STICKY_O; assign c_a[0] = b0.CNT_O;
    assign o_a[1] = b1.O; assign v_a[1] = b1.VALID_O; assign s_a[1] = b1.STICKY_O; assign c_a[1] = b1.CNT_O;
    assign o_a[2] = b2.O; assign v_a[2] = b2.VALID_O; assign s_a[2] = b2.STICKY_O; assign c_a[2] = b2.CNT_O;

    function automatic bit ref_out(int d, logic [63:0] r);
        case (d)
            0: return |(r[4:0] ^ 5'b00111);
            1: return &r[16:0];
            default: return ^(r[2:0] ^ 3'b101);
        endcase
    endfunction

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
        end
    endtask

    task automatic cyc(bit e, bit v, bit c, logic [63:0] a0, logic [63:0] a1, logic [63:0] a2);
        @(posedge clk);
        #1;
        en = e; vi = v; sclr = c; r0 = a0; r1 = a1; r2 = a2;
        if (e) acc_cnt++;
        if (e && v) begin
            q_due[0].push_back(acc_cnt + LAT[0] - 1); q_exp[0].push_back(ref_out(0, a0));
            q_due[1].push_back(acc_cnt + LAT[1] - 1); q_exp[1].push_back(ref_out(1, a1));
            q_due[2].push_back(acc_cnt + LAT[2] - 1); q_exp[2].push_back(ref_out(2, a2));
        end
    endtask

    task automatic apply_reset();
        CLR_N = 1'b0; en = 1'b0; vi = 1'b0; sclr = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_o", d, o_a[d], 0);
            check("rst_valid", d, v_a[d], 0);
            check("rst_sticky", d, s_a[d], 0);
            check("rst_cnt", d, c_a[d], 0);
            q_due[d].delete(); q_exp[d].delete();
            m_sticky[d] = 1'b0; m_cnt[d] = 0; prev_o[d] = 1'b0; prev_v[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        CLR_N = 1'b1;
    endtask

    function automatic logic [63:0] and_pat();
        logic [63:0] r = 64'h1FFFF;
        if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 16)] = 1'b0;
        else if ($urandom_range(0, 2) == 0) r = {$urandom, $urandom};
        return r;
    endfunction

    initial forever begin
        bit e, c, live, hit;
        @(posedge clk);
        live = CLR_N; e = en; c = sclr;
        if (live && e) mon_cnt++;
        @(negedge clk);
        if (live && CLR_N)
            for (int d = 0; d < 3; d++) begin
                hit = 1'b0;
                if (e) begin
                    if (q_due[d].size() > 0 && q_due[d][0] == mon_cnt) begin
                        hit = q_exp[d][0];
                        check("valid_out", d, v_a[d], 1);
                        check("o", d, o_a[d], hit);
                        void'(q_due[d].pop_front());
                        void'(q_exp[d].pop_front());
                    end else check("valid_idle", d, v_a[d], 0);
                end else begin
                    check("freeze_valid", d, v_a[d], prev_v[d]);
                    check("freeze_o", d, o_a[d], prev_o[d]);
                end
                m_sticky[d] = hit | (m_sticky[d] & !c);
                m_cnt[d] = c ? int'(hit) : (hit && m_cnt[d] < 65535) ? m_cnt[d] + 1 : m_cnt[d];
                check("sticky", d, s_a[d], m_sticky[d]);
                check("cnt", d, c_a[d], CNT_ON ? m_cnt[d] : 0);
                prev_v[d] = v_a[d];
                prev_o[d] = o_a[d];
            end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        apply_reset();
        cyc(1, 1, 0, 64'b00111, 64'h1FFFF, 64'b101);
        cyc(1, 1, 0, 64'b00110, 64'h0FFFF, 64'b100);
        cyc(1, 1, 0, 64'b00111, 64'h1FFFF, 64'b111);
        cyc(1, 0, 0, 64'b0, 64'h0, 64'b0);
        cyc(1, 1, 0, 64'b00110, 64'h1FFFF, 64'b001);
        repeat (3) cyc(0, 0, 0, 64'b0, 64'h0, 64'b0);
        repeat (3) cyc(1, 0, 0, 64'b0, 64'h0, 64'b0);
        cyc(0, 0, 1, 64'b0, 64'h0, 64'b0);
        cyc(1, 1, 0, 64'b00110, 64'h1FFFF, 64'b100);
        cyc(1, 1, 0, 64'b00110, 64'h1FFFF, 64'b100);
        @(posedge clk);
        #2;
        apply_reset();
        repeat (4) cyc(1, 0, 0, 64'b0, 64'h0, 64'b0);
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                {$urandom, $urandom}, and_pat(), {$urandom, $urandom});
            if (n == 300) begin
                @(posedge clk);
                #3;
                apply_reset();
            end
        end
`ifdef LOGIC_REDUCE_CNT_EN
        cyc(1, 0, 1, 64'b0, 64'h0, 64'b0);
        for (int n = 0; n < 65540; n++) cyc(1, 1, 0, 64'b00110, 64'h1FFFF, 64'b100);
        cyc(1, 1, 1, 64'b00110, 64'h1FFFF, 64'b100);
        cyc(1, 1, 0, 64'b00111, 64'h0, 64'b101);
`endif
        repeat (5) cyc(1, 0, 0, 64'b0, 64'h0, 64'b0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check("drain", d, q_due[d].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logic_reduce_pipe.md
LOGIC_REDUCE_PIPE -- requirements
Module: logic_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 5: number of data inputs, legal range 2..64.
REQ-002 Parameter INV_MASK, default 5'b00111 (WIDTH bits): bit k = 1 inverts input k before reduction.
REQ-003 Parameter MODE, default 0: reduction operator; 0 = OR, 1 = AND, 2 = XOR; other values illegal.
REQ-004 C  input  1  clock; all state on rising edge.
REQ-005 CLR_N  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  pipeline clock enable; low freezes the pipeline.
REQ-007 VALID_I  input  1  marks I as a sample to be reduced.
REQ-008 I  input  WIDTH  data inputs, bit k = input k.
REQ-009 STICKY_CLR  input  1  synchronous clear of STICKY_O and CNT_O.
REQ-010 O  output  1  registered reduction result.
REQ-011 VALID_O  output  1  O carries the result of a VALID_I sample.
REQ-012 STICKY_O  output  1  set once any valid result equals 1.
REQ-013 CNT_O  output  16  count of valid results equal to 1.

Function
REQ-014 Per-bit pre-stage: x[k] = I[k] XOR INV_MASK[k], combinational.
REQ-015 Reduction is a registered tree of fan-in 4: stage s groups at most 4 partials of stage s-1 in index order; a group of 1 passes through registered.
REQ-016 Stage count L = ceil(log4(WIDTH)), minimum 1; WIDTH=5 gives L=2, WIDTH=16 gives L=2, WIDTH=17 gives L=3.
REQ-017 VALID_I travels a parallel L-deep shift register; VALID_O and O align with the same sample.
REQ-018 Latency: with EN held high, a sample at edge n appears on O/VALID_O after edge n+L-1 (i.e. visible L cycles after VALID_I is sampled).
REQ-019 Throughput one sample per enabled cycle; no back-pressure.
REQ-020 EN low: every tree and valid register holds its value; O and VALID_O unchanged.
REQ-021 Data registers load every enabled cycle regardless of VALID_I; O is meaningful only when VALID_O = 1.
REQ-022 STICKY_O sets on an enabled cycle that updates VALID_O = 1 with O = 1 (evaluated at the final stage's new value).
REQ-023 CNT_O increments under the same condition as REQ-022; saturates at 16'hFFFF.
REQ-024 STICKY_CLR acts on every edge, independent of EN.
REQ-025 STICKY_CLR coincident with a set/increment: STICKY_O = 1, CNT_O = 1.
REQ-026 MODE and INV_MASK are static; no run-time mode change.

Reset
REQ-027 CLR_N low asynchronously forces all tree registers, O, VALID_O, STICKY_O to 0 and CNT_O to 0.
REQ-028 Reset mid-operation discards all in-flight samples; no VALID_O pulse may appear for samples accepted before reset.
REQ-029 Release of CLR_N is synchronous to C; first sample accepted on the first rising edge with CLR_N high.

Configuration
REQ-030 Macro LOGIC_REDUCE_CNT_EN defined: CNT_O counter compiled in per REQ-023/REQ-025.
REQ-031 Macro LOGIC_REDUCE_CNT_EN undefined: no counter flops; CNT_O tied to 16'h0000; STICKY_O unaffected.

Verification
REQ-032 Defaults (WIDTH=5, INV_MASK=5'b00111, MODE=0), EN=1, I=5'b00111, VALID_I=1 -> O=0, VALID_O=1 two cycles later; I=5'b00110 -> O=1.
REQ-033 Defaults, stream I=00111,00110,00111 back-to-back -> O = 0,1,0 on consecutive cycles, VALID_O high for 3 cycles.
REQ-034 Sample I=5'b00110 in flight, EN low 3 cycles -> O/VALID_O frozen; after EN high, O=1 emerges with total 2 enabled cycles of latency.
REQ-035 WIDTH=17, MODE=1, INV_MASK=0, I=all ones then bit 16 cleared -> O = 1 then 0, latency 3.
REQ-036 CNT_EN build, CNT_O preloaded to 16'hFFFE by 65534 hits, two more O=1 results -> CNT_O=16'hFFFF; STICKY_CLR with a hit -> CNT_O=1, STICKY_O=1.
REQ-037 CLR_N pulsed low while VALID_I sample in flight -> all outputs 0 immediately, no VALID_O after release.
